// File: rtl/stream_packer_pkg.sv
// Shared helpers for the stream packer: lane-to-bit-offset mapping.
package stream_packer_pkg;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Valid/ready width up-converter: packs RATIO narrow beats (lane 0 first) into one
// wide registered word, with early flush on in_last_i and per-lane strobes.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [IN_WIDTH-1:0]       in_data_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [IN_WIDTH*RATIO-1:0] out_data_o,
  output logic [RATIO-1:0]          out_strb_o,
  output logic                      out_last_o
);

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  typedef logic [IN_WIDTH*RATIO-1:0] pack_word_t;

  if (RATIO < 2) begin : g_ratio_check
    $error("stream_packer: RATIO must be >= 2");
  end

  pack_word_t       acc_q, acc_d;
  logic [RATIO-1:0] acc_strb_q, acc_strb_d;
  logic [CNT_W-1:0] cnt_q;

  pack_word_t       out_data_q;
  logic [RATIO-1:0] out_strb_q;
  logic             out_last_q;
  logic             out_valid_q;

  logic accept;
  logic complete;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign complete   = accept & ((cnt_q == CNT_MAX) | in_last_i);

  // Accumulator with the incoming beat merged into lane cnt_q.
  always_comb begin
    acc_d      = acc_q;
    acc_strb_d = acc_strb_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        acc_d[lane_lsb(k, IN_WIDTH) +: IN_WIDTH] = in_data_i;
        acc_strb_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_strb_q  <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (complete) begin
      // Drain and reload can coincide, so valid simply stays high.
      out_data_q  <= acc_d;
      out_strb_q  <= acc_strb_d;
      out_last_q  <= in_last_i;
      out_valid_q <= 1'b1;
      acc_q       <= '0;
      acc_strb_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        acc_q      <= acc_d;
        acc_strb_q <= acc_strb_d;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
    end
  end

  // Strobes are a thermometer code from lane 0; any gap is a design error.
  always_ff @(posedge clk) begin
    if (!rst && out_valid_q) begin
      assert ((out_strb_q & (out_strb_q + RATIO'(1))) == '0)
        else $error("stream_packer: non-contiguous strobe %b", out_strb_q);
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed + random bench for stream_packer (IN_WIDTH=8, RATIO=4) with a word scoreboard.
module tb_stream_packer;

  localparam int IW = 8;
  localparam int R  = 4;

  typedef struct packed {
    logic [IW*R-1:0] data;
    logic [R-1:0]    strb;
    logic            last;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [IW-1:0]   in_data_i;
  logic            in_last_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [IW*R-1:0] out_data_o;
  logic [R-1:0]    out_strb_o;
  logic            out_last_o;

  stream_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_words = 0;
  int retries_total = 0;

  word_t           sb_q[$];
  logic [IW*R-1:0] m_acc;
  logic [R-1:0]    m_strb;
  int              m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = '0;
    m_strb = '0;
    m_cnt  = 0;
  endtask

  task automatic model_accept(input logic [IW-1:0] d, input logic l);
    word_t w;
    m_acc[m_cnt*IW +: IW] = d;
    m_strb[m_cnt] = 1'b1;
    if (m_cnt == R-1 || l) begin
      w.data = m_acc;
      w.strb = m_strb;
      w.last = l;
      sb_q.push_back(w);
      model_reset();
    end else begin
      m_cnt++;
    end
  endtask

  // Presents one beat and returns after the edge that accepted it.
  task automatic send(input logic [IW-1:0] d, input logic l, output int retries);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    retries    = 0;
    forever begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        #1;
        model_accept(d, l);
        break;
      end
      retries++;
      if (retries > 100) begin
        check("send_timeout", 64'(retries), 64'(0));
        break;
      end
      @(posedge clk);
      #1;
    end
    retries_total += retries;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  // Output monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 64'(out_data_o), 64'(0));
      end else begin
        word_t w;
        w = sb_q.pop_front();
        check("word_data", 64'(out_data_o), 64'(w.data));
        check("word_strb", 64'(out_strb_o), 64'(w.strb));
        check("word_last", 64'(out_last_o), 64'(w.last));
        n_words++;
      end
    end
  end

  initial begin
    int r;
    int words_before;
    idle();
    out_ready_i = 1'b1;
    model_reset();
    #1;
    do_reset(3);

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(out_valid_o), 64'(0));
    check("rst_data",  64'(out_data_o),  64'(0));
    check("rst_strb",  64'(out_strb_o),  64'(0));
    check("rst_last",  64'(out_last_o),  64'(0));
    check("rst_ready", 64'(in_ready_o),  64'(1));
    @(posedge clk); #1;

    // Full word, back-to-back
    send(8'h11, 1'b0, r);
    send(8'h22, 1'b0, r);
    send(8'h33, 1'b0, r);
    send(8'h44, 1'b0, r);
    idle();
    check("full_valid", 64'(out_valid_o), 64'(1));
    check("full_data",  64'(out_data_o),  64'h44332211);
    check("full_strb",  64'(out_strb_o),  64'hf);
    check("full_last",  64'(out_last_o),  64'(0));
    @(posedge clk); #1;

    // Early flush
    send(8'hAA, 1'b0, r);
    send(8'hBB, 1'b1, r);
    idle();
    check("flush_data", 64'(out_data_o), 64'h0000BBAA);
    check("flush_strb", 64'(out_strb_o), 64'h3);
    check("flush_last", 64'(out_last_o), 64'(1));
    // single-lane word confirms the next word started at lane 0
    send(8'hC7, 1'b1, r);
    idle();
    check("single_data", 64'(out_data_o), 64'h000000C7);
    check("single_strb", 64'(out_strb_o), 64'h1);
    @(posedge clk); #1;

    // Back-pressure
    out_ready_i = 1'b0;
    send(8'hD1, 1'b0, r);
    send(8'hD2, 1'b0, r);
    send(8'hD3, 1'b0, r);
    send(8'hD4, 1'b0, r);
    in_data_i  = 8'h55;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(in_ready_o),  64'(0));
      check("bp_valid", 64'(out_valid_o), 64'(1));
      check("bp_data",  64'(out_data_o),  64'hD4D3D2D1);
    end
    @(posedge clk); #1;
    check("bp_no_accept_cnt", 64'(m_cnt), 64'(0));
    out_ready_i = 1'b1;
    words_before = n_words;
    send(8'h55, 1'b0, r);
    check("release_same_cycle", 64'(r), 64'(0));
    check("release_drained", 64'(n_words - words_before), 64'(1));
    send(8'h66, 1'b0, r);
    send(8'h77, 1'b1, r);
    idle();
    check("release_word", 64'(out_data_o), 64'h00776655);
    @(posedge clk); #1;

    // Streaming: 64 random beats with no back-pressure
    words_before = n_words;
    retries_total = 0;
    for (int i = 0; i < 64; i++) send(8'($urandom), 1'b0, r);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("stream_words", 64'(n_words - words_before), 64'(16));
    check("stream_no_stall", 64'(retries_total), 64'(0));

    // Reset mid-word
    send(8'hE1, 1'b0, r);
    send(8'hE2, 1'b0, r);
    idle();
    do_reset(1);
    send(8'h01, 1'b0, r);
    send(8'h02, 1'b0, r);
    send(8'h03, 1'b0, r);
    send(8'h04, 1'b0, r);
    idle();
    check("midrst_data", 64'(out_data_o), 64'h04030201);
    check("midrst_strb", 64'(out_strb_o), 64'hf);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    check("idle_valid", 64'(out_valid_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
